// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and width for the execute-stage ALU
// Purpose: opcode encodings and datapath width used by alu_top and alu_adder32.
// Ports: none (package).
package alu_pkg;
  localparam int       ALU_W   = 32;
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;
endpackage

// File: rtl/alu_adder32.sv
// rtl/alu_adder32.sv - 32-bit adder of eight 4-bit carry-lookahead groups
// Purpose: gate-level adder; each 4-bit group resolves its internal carries by
//   lookahead, and group carries ripple from group 0 to group 7.
// Ports:
//   a, b  in  [31:0]  addends
//   cin   in  1       carry into bit 0
//   sum   out [31:0]  a + b + cin modulo 2^32
//   cout  out 1       carry out of bit 31
module alu_adder32
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             cin,
  output logic [ALU_W-1:0] sum,
  output logic             cout
);

  logic [ALU_W-1:0] g;
  logic [ALU_W-1:0] p;
  logic [ALU_W-1:0] c;   // carry into each bit position
  logic [8:0]       gc;  // carry into each 4-bit group; gc[8] is the final carry

  assign g     = a & b;
  assign p     = a ^ b;
  assign gc[0] = cin;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int L = 4 * k;
    assign c[L]   = gc[k];
    assign c[L+1] = g[L] | (p[L] & gc[k]);
    assign c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & gc[k]);
    assign c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                  | (p[L+2] & p[L+1] & p[L] & gc[k]);
    assign gc[k+1] = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                   | (p[L+3] & p[L+2] & p[L+1] & g[L])
                   | (p[L+3] & p[L+2] & p[L+1] & p[L] & gc[k]);
  end

  assign sum  = p ^ c;
  assign cout = gc[8];

endmodule

// File: rtl/alu_top.sv
// rtl/alu_top.sv - 32-bit AND/OR/ADD/SUB ALU with NZCV flags and flag shadow register
// Purpose: combinational execute-stage ALU; flags_q keeps the previous cycle's flags.
// Ports:
//   clk      in   1       system clock, rising edge
//   rst_n    in   1       asynchronous active-low reset (clears flags_q only)
//   A, B     in   [31:0]  operands
//   ALUOp    in   [1:0]   00=AND 01=OR 10=ADD 11=SUB
//   Result   out  [31:0]  combinational result
//   N,V,C,Z  out  1       combinational flags
//   flags_q  out  [3:0]   registered {N,V,C,Z}
module alu_top
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic [1:0]       ALUOp,
  output logic [ALU_W-1:0] Result,
  output logic             N,
  output logic             V,
  output logic             C,
  output logic             Z,
  output logic [3:0]       flags_q
);

  logic             is_sub;
  logic             is_arith;
  logic [ALU_W-1:0] b_eff;
  logic [ALU_W-1:0] sum;
  logic             cout;

  assign is_sub   = (ALUOp == ALU_SUB);
  assign is_arith = (ALUOp == ALU_ADD) || (ALUOp == ALU_SUB);

  // SUB shares the adder: A + ~B + 1.
  assign b_eff = B ^ {ALU_W{is_sub}};

  alu_adder32 u_adder (
    .a    (A),
    .b    (b_eff),
    .cin  (is_sub),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    Result = sum;
    case (ALUOp)
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      default: Result = sum;
    endcase
  end

  assign N = Result[ALU_W-1];
  assign Z = (Result == '0);
  assign C = is_arith & cout;
  // Overflow on the adder's actual operands: same sign in, different sign out.
  // Using b_eff covers both ADD and SUB with one expression.
  assign V = is_arith & ~(A[ALU_W-1] ^ b_eff[ALU_W-1]) & (A[ALU_W-1] ^ Result[ALU_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= {N, V, C, Z};
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// tb/tb_alu_top.sv - directed and randomized self-checking bench for alu_top
module tb_alu_top;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  ALUOp;
  logic [31:0] Result;
  logic        N, V, C, Z;
  logic [3:0]  flags_q;

  int n_cmp;
  int n_bad;

  alu_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .ALUOp   (ALUOp),
    .Result  (Result),
    .N       (N),
    .V       (V),
    .C       (C),
    .Z       (Z),
    .flags_q (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; A = 32'h0; B = 32'h0; ALUOp = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (flags_q !== 4'b0000) begin
      $display("FAIL reset_flags_q got=%b exp=0000", flags_q);
      n_bad++;
    end
  endtask

  // Each table row: A, B, expected Result, expected {N,V,C,Z}
  task automatic test_and();
    logic [31:0] ta [3] = '{32'hFFFFFFFF, 32'h00000000, 32'hF0000000};
    logic [31:0] tb [3] = '{32'h0F0F0F0F, 32'h00000000, 32'h80000000};
    logic [31:0] tr [3] = '{32'h0F0F0F0F, 32'h00000000, 32'h80000000};
    logic [3:0]  tf [3] = '{4'b0000, 4'b0001, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ALUOp = 2'b00; A = ta[i]; B = tb[i];
      #1;
      n_cmp++;
      if ({Result, N, V, C, Z} !== {tr[i], tf[i]}) begin
        $display("FAIL and[%0d] got R=%h NVCZ=%b exp R=%h NVCZ=%b", i, Result, {N,V,C,Z}, tr[i], tf[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_or();
    logic [31:0] ta [3] = '{32'h80000000, 32'h00000000, 32'h12340000};
    logic [31:0] tb [3] = '{32'h00000001, 32'h00000000, 32'h00005678};
    logic [31:0] tr [3] = '{32'h80000001, 32'h00000000, 32'h12345678};
    logic [3:0]  tf [3] = '{4'b1000, 4'b0001, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ALUOp = 2'b01; A = ta[i]; B = tb[i];
      #1;
      n_cmp++;
      if ({Result, N, V, C, Z} !== {tr[i], tf[i]}) begin
        $display("FAIL or[%0d] got R=%h NVCZ=%b exp R=%h NVCZ=%b", i, Result, {N,V,C,Z}, tr[i], tf[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_add();
    logic [31:0] ta [5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h80000000, 32'h0FFFFFFF};
    logic [31:0] tb [5] = '{32'h00000001, 32'h00000001, 32'h00000003, 32'h80000000, 32'h00000001};
    logic [31:0] tr [5] = '{32'h80000000, 32'h00000000, 32'h00000005, 32'h00000000, 32'h10000000};
    logic [3:0]  tf [5] = '{4'b1100, 4'b0011, 4'b0000, 4'b0111, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ALUOp = 2'b10; A = ta[i]; B = tb[i];
      #1;
      n_cmp++;
      if ({Result, N, V, C, Z} !== {tr[i], tf[i]}) begin
        $display("FAIL add[%0d] got R=%h NVCZ=%b exp R=%h NVCZ=%b", i, Result, {N,V,C,Z}, tr[i], tf[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_sub();
    logic [31:0] ta [5] = '{32'h00000003, 32'h00000000, 32'h80000000, 32'h00000005, 32'h7FFFFFFF};
    logic [31:0] tb [5] = '{32'h00000002, 32'h00000001, 32'h00000001, 32'h00000005, 32'hFFFFFFFF};
    logic [31:0] tr [5] = '{32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h80000000};
    logic [3:0]  tf [5] = '{4'b0010, 4'b1000, 4'b0110, 4'b0011, 4'b1100};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ALUOp = 2'b11; A = ta[i]; B = tb[i];
      #1;
      n_cmp++;
      if ({Result, N, V, C, Z} !== {tr[i], tf[i]}) begin
        $display("FAIL sub[%0d] got R=%h NVCZ=%b exp R=%h NVCZ=%b", i, Result, {N,V,C,Z}, tr[i], tf[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_flags_q();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (flags_q !== 4'b0000) begin
      $display("FAIL flags_q_held_reset got=%b exp=0000", flags_q);
      n_bad++;
    end
    @(negedge clk);
    rst_n = 1'b1; ALUOp = 2'b10; A = 32'hFFFFFFFF; B = 32'h00000001;
    @(posedge clk);
    #1;
    n_cmp++;
    if (flags_q !== 4'b0011) begin
      $display("FAIL flags_q_load got=%b exp=0011", flags_q);
      n_bad++;
    end
    // Change inputs: flags_q must hold until the next edge, then follow.
    #2;
    ALUOp = 2'b01; A = 32'h80000000; B = 32'h00000001;
    #1;
    n_cmp++;
    if (flags_q !== 4'b0011) begin
      $display("FAIL flags_q_hold_between_edges got=%b exp=0011", flags_q);
      n_bad++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (flags_q !== 4'b1000) begin
      $display("FAIL flags_q_second_load got=%b exp=1000", flags_q);
      n_bad++;
    end
    // Asynchronous reset between edges; combinational outputs must stay valid.
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (flags_q !== 4'b0000) begin
      $display("FAIL flags_q_async_clear got=%b exp=0000", flags_q);
      n_bad++;
    end
    n_cmp++;
    if ({Result, N, V, C, Z} !== {32'h80000001, 4'b1000}) begin
      $display("FAIL comb_during_reset got R=%h NVCZ=%b exp R=80000001 NVCZ=1000", Result, {N,V,C,Z});
      n_bad++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (flags_q !== 4'b0000) begin
      $display("FAIL flags_q_reset_over_edge got=%b exp=0000", flags_q);
      n_bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, er;
    logic [32:0] s33;
    logic [1:0]  op;
    logic        en, ev, ec, ez;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      op = 2'($urandom_range(0, 3));
      ea = $urandom;
      eb = $urandom;
      if (i % 8 == 1) ea = 32'h80000000;
      if (i % 8 == 2) eb = 32'hFFFFFFFF;
      if (i % 8 == 3) eb = ea;
      if (i % 8 == 4) ea = 32'h7FFFFFFF;
      case (op)
        2'b00: begin er = ea & eb; ec = 1'b0; ev = 1'b0; end
        2'b01: begin er = ea | eb; ec = 1'b0; ev = 1'b0; end
        2'b10: begin
          s33 = {1'b0, ea} + {1'b0, eb};
          er  = s33[31:0];
          ec  = s33[32];
          ev  = (ea[31] == eb[31]) && (er[31] != ea[31]);
        end
        default: begin
          er = ea - eb;
          ec = (ea >= eb);
          ev = (ea[31] != eb[31]) && (er[31] != ea[31]);
        end
      endcase
      en = er[31];
      ez = (er == 32'h0);
      ALUOp = op; A = ea; B = eb;
      #1;
      n_cmp++;
      if ({Result, N, V, C, Z} !== {er, en, ev, ec, ez}) begin
        $display("FAIL rand[%0d] op=%b A=%h B=%h got R=%h NVCZ=%b exp R=%h NVCZ=%b",
                 i, op, ea, eb, Result, {N,V,C,Z}, er, {en,ev,ec,ez});
        n_bad++;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (flags_q !== {en, ev, ec, ez}) begin
        $display("FAIL rand_flags_q[%0d] got=%b exp=%b", i, flags_q, {en,ev,ec,ez});
        n_bad++;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_and();
    test_or();
    test_add();
    test_sub();
    test_flags_q();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
